// File: rtl/ripple_add_4bit.sv
// Registered ripple-carry adder.
// A chain of WIDTH full-adder stages is built from per-bit dataflow equations.
// The sum, carry-out and signed-overflow flag are captured one clock after
// in_valid. The outputs hold their values while in_valid is low.
module ripple_add_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid
);

  // Carry chain: c[i] is the carry into stage i, and c[WIDTH] leaves the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = carry_in;

  // One full adder per bit. The carry ripples upward, stage by stage.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;

  // Next-state selection: load new results on a valid operand, otherwise hold.
  // The select ensures that junk operands present while in_valid is low
  // never reach the registers.
  always_comb begin
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d       = s;
      carry_out_d = c[WIDTH];
      overflow_d  = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  // Output registers. Reset clears all of them immediately, without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_add_4bit.sv
// Self-checking bench for ripple_add_4bit.
// It drives directed vectors with hand-computed results, then runs an
// exhaustive sweep against an integer reference.
module tb_ripple_add_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       carry_in = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] sum;
  logic       carry_out;
  logic       overflow;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  ripple_add_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the comparison and reports a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Checks all four outputs and prints one line per transaction.
  task automatic check_out(input string tag, input logic [3:0] es, input logic ec,
                           input logic eo, input logic ev);
    check({tag, ".sum"},       {28'd0, sum},       {28'd0, es});
    check({tag, ".carry_out"}, {31'd0, carry_out}, {31'd0, ec});
    check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, eo});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    $display("%s: sum=%b cout=%b ovf=%b vld=%b", tag, sum, carry_out, overflow, out_valid);
  endtask

  // Presents operands and advances to 1 time unit after the capturing edge.
  task automatic step(input logic [3:0] va, input logic [3:0] vb,
                      input logic vc, input logic vv);
    a = va; b = vb; carry_in = vc; in_valid = vv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hold reset over a couple of edges, then check the cleared outputs.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Produce a nonzero result, then assert reset between edges.
    step(4'h5, 4'h5, 1'b0, 1'b1);
    check_out("pre_reset_5p5", 4'hA, 1'b0, 1'b1, 1'b1);
    #3 rst = 1'b1;
    #1;
    check_out("async_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero case and back-to-back small sums.
    step(4'h0, 4'h0, 1'b0, 1'b1); check_out("0p0p0", 4'h0, 1'b0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 1'b1, 1'b1); check_out("0p0p1", 4'h1, 1'b0, 1'b0, 1'b1);
    step(4'h1, 4'h1, 1'b0, 1'b1); check_out("1p1p0", 4'h2, 1'b0, 1'b0, 1'b1);
    step(4'h1, 4'h1, 1'b1, 1'b1); check_out("1p1p1", 4'h3, 1'b0, 1'b0, 1'b1);
    step(4'h3, 4'h6, 1'b0, 1'b1); check_out("3p6p0", 4'h9, 1'b0, 1'b1, 1'b1);

    // Carry ripples through every stage.
    step(4'hF, 4'h1, 1'b0, 1'b1); check_out("Fp1p0", 4'h0, 1'b1, 1'b0, 1'b1);
    step(4'hF, 4'hF, 1'b1, 1'b1); check_out("FpFp1", 4'hF, 1'b1, 1'b0, 1'b1);

    // Signed overflow.
    step(4'h7, 4'h1, 1'b0, 1'b1); check_out("7p1p0", 4'h8, 1'b0, 1'b1, 1'b1);
    step(4'h8, 4'h8, 1'b0, 1'b1); check_out("8p8p0", 4'h0, 1'b1, 1'b1, 1'b1);

    // Hold: changing operands with in_valid low must not disturb the outputs.
    step(4'h5, 4'h2, 1'b0, 1'b1); check_out("5p2p0", 4'h7, 1'b0, 1'b0, 1'b1);
    step(4'hF, 4'hF, 1'b1, 1'b0); check_out("hold1", 4'h7, 1'b0, 1'b0, 1'b0);
    step(4'h8, 4'h9, 1'b0, 1'b0); check_out("hold2", 4'h7, 1'b0, 1'b0, 1'b0);
    step(4'h7, 4'h7, 1'b1, 1'b0); check_out("hold3", 4'h7, 1'b0, 1'b0, 1'b0);

    // Mid-stream reset: the operation pending during reset is lost.
    step(4'h9, 4'h3, 1'b0, 1'b1); check_out("9p3p0", 4'hC, 1'b0, 1'b0, 1'b1);
    a = 4'h2; b = 4'h2; carry_in = 1'b0; in_valid = 1'b1;
    #3 rst = 1'b1;
    #1;
    check_out("mid_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("mid_reset_edge", 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(4'h6, 4'h1, 1'b1, 1'b1); check_out("post_reset_6p1p1", 4'h8, 1'b0, 1'b1, 1'b1);

    // Exhaustive sweep against an integer reference, back-to-back.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] va, vb;
      logic       vc;
      int         full, sa, sb, ssum;
      logic [4:0] fv;
      va = i[3:0];
      vb = i[7:4];
      vc = i[8];
      full = int'(va) + int'(vb) + int'(vc);
      fv = full[4:0];
      sa = va[3] ? int'(va) - 16 : int'(va);
      sb = vb[3] ? int'(vb) - 16 : int'(vb);
      ssum = sa + sb + int'(vc);
      step(va, vb, vc, 1'b1);
      check_out($sformatf("exh_%0h_%0h_%0d", va, vb, vc), fv[3:0], fv[4],
                (ssum > 7) || (ssum < -8), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_add_4bit.md
Name: ripple_add_4bit

Overview:
- Registered 4-bit ripple-carry adder: sum = a + b + carry_in, computed as an explicit chain of per-bit full adders in dataflow form.
- Result, carry-out and signed-overflow flag are captured in output registers one clock after the operands are presented with in_valid.
- Used as a small arithmetic leaf block in combinational/datapath designs that need a registered adder boundary.

Parameters:
- WIDTH, 4, operand and sum width in bits; the carry ripples through WIDTH full-adder stages. Default 4 is the only configuration the bench must cover.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  operand A, unsigned; also read as two's-complement for overflow
- b  input  WIDTH  operand B, same encoding as a
- carry_in  input  1  carry into bit 0
- in_valid  input  1  operands valid this cycle; capture on the rising clk edge
- sum  output  WIDTH  registered (a + b + carry_in) mod 2^WIDTH
- carry_out  output  1  registered carry out of bit WIDTH-1
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, sum=0, carry_out=0, overflow=0 and out_valid=0, immediately and without waiting for a clk edge. Release is sampled on the next rising clk.
- Combinational core, per bit i (0..WIDTH-1):
  - c[0] = carry_in
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - No behavioural "+" operator in the core; each stage is continuous-assign dataflow.
- Registering, on each rising clk edge with rst=0:
  - If in_valid=1: sum <= s, carry_out <= c[WIDTH], overflow <= c[WIDTH] ^ c[WIDTH-1], out_valid <= 1.
  - If in_valid=0: sum, carry_out and overflow hold their previous values; out_valid <= 0.
- Latency and throughput:
  - Exactly 1 cycle from the capturing edge to outputs.
  - One operation accepted per cycle, back-to-back, with no stalls and no backpressure.
- Arithmetic: {carry_out, sum} equals the full (WIDTH+1)-bit unsigned sum of a + b + carry_in.
  - Maximum case: a=b=all ones, carry_in=1 gives {1, all ones}.
- X/unknown operands when in_valid=0 must not disturb the held outputs.
- Reset asserted mid-stream clears outputs at once. Any operation captured before reset is lost, and the first operation after release appears one cycle after its capture edge.

Test Plan:
- Reset and zero case:
  - Assert rst asynchronously between clock edges -> all outputs 0 immediately.
  - Release rst, apply a=0000, b=0000, cin=0, in_valid=1 -> next edge: sum=0000, carry_out=0, overflow=0, out_valid=1.
- Small sums, back-to-back on consecutive cycles, each result one cycle later:
  - 0+0+1 -> sum=0001, carry_out=0
  - 1+1+0 -> sum=0010, carry_out=0
  - 1+1+1 -> sum=0011, carry_out=0
  - 3+6+0 -> sum=1001, carry_out=0, overflow=1
- Carry ripple through all stages:
  - 1111+0001+0 -> sum=0000, carry_out=1, overflow=0
  - 1111+1111+1 -> sum=1111, carry_out=1, overflow=0
- Signed overflow:
  - 0111+0001+0 -> sum=1000, carry_out=0, overflow=1
  - 1000+1000+0 -> sum=0000, carry_out=1, overflow=1
- Hold and valid behaviour:
  - Valid op 0101+0010+0 (sum=0111), then in_valid=0 with changing/X operands for 3 cycles -> sum stays 0111, out_valid=0 on those cycles.
  - Mid-stream rst pulse -> outputs 0 immediately; next valid op after release appears 1 cycle later.
- Exhaustive check: all 512 combinations of a, b, carry_in with in_valid=1 -> {carry_out, sum} == a+b+carry_in and overflow matches the signed reference, each checked one cycle after capture.
